// File: rtl/cpu_board_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_board_pkg : shared widths and idle output values for the shell    |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
package cpu_board_pkg;

  typedef struct packed {
    logic [7:0]  led;
    logic [11:0] digi;
    logic        uart_tx;
  } board_out_t;

  localparam logic [7:0]  LED_IDLE  = 8'h00;
  localparam logic [11:0] DIGI_IDLE = 12'hFFF;
  localparam logic        UART_IDLE = 1'b1;

  localparam board_out_t BOARD_IDLE = '{led: LED_IDLE, digi: DIGI_IDLE, uart_tx: UART_IDLE};

  function automatic int DEB_CNT_W(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

  // hold counter only has to reach RST_HOLD-1
  function automatic int RST_HOLD_W(input int hold);
    return (hold < 2) ? 1 : $clog2(hold);
  endfunction

endpackage
`default_nettype wire

// File: rtl/CPU_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | CPU_pipeline : behavioural stand-in for the pipelined core's pin I/O  |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module CPU_pipeline (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  switch,
  input  logic        UART_RX,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        UART_TX
);

  // led/digi reset values differ from the board idle values so the shell's mask is observable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led     <= 8'hFF;
      digi    <= 12'h000;
      UART_TX <= 1'b1;
    end else begin
      led     <= switch;
      digi    <= {3'b000, UART_RX, switch};
      UART_TX <= UART_RX;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sw_debounce : one-bit synchroniser + stability counter + output flop  |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module sw_debounce
  import cpu_board_pkg::*;
#(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int CNT_W = DEB_CNT_W(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // counter only runs while the synchronised input disagrees with deb, so it tops out at CNT_LAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b00;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_board_shell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_board_shell : pin conditioning shell around CPU_pipeline          |
// |   optional divided core clock under macro CLK_DIV_EN                  |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module cpu_board_shell
  import cpu_board_pkg::*;
#(
  parameter int NUM_SW          = 8,
  parameter int DEB_CYCLES      = 250000,
  parameter int RST_SYNC_STAGES = 2,
  parameter int RST_HOLD        = 16,
  parameter int DIV_HALF        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw,
  input  logic              UART_RX,
  output logic [7:0]        led,
  output logic [11:0]       digi,
  output logic              UART_TX,
  output logic              cpu_rst
);

  localparam int HOLD_W = RST_HOLD_W(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  if (NUM_SW < 1 || NUM_SW > 8 || DEB_CYCLES < 1 || RST_SYNC_STAGES < 2 ||
      RST_HOLD < 1 || DIV_HALF < 1) begin : g_param_check
    $error("cpu_board_shell: parameter out of range");
  end

  logic core_clk;

`ifdef CLK_DIV_EN
  localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             core_clk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      core_clk_q <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt    <= '0;
      core_clk_q <= ~core_clk_q;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign core_clk = core_clk_q;
`else
  assign core_clk = clk;
`endif

  logic [RST_SYNC_STAGES-1:0] rst_chain;
  logic [HOLD_W-1:0]          hold_cnt;
  logic                       rst_sync;

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) rst_chain <= '1;
    else       rst_chain <= {rst_chain[RST_SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_sync = rst_chain[RST_SYNC_STAGES-1];

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      cpu_rst  <= 1'b1;
    end else if (rst_sync) begin
      hold_cnt <= '0;
      cpu_rst  <= 1'b1;
    end else if (cpu_rst) begin
      if (hold_cnt == HOLD_LAST) cpu_rst  <= 1'b0;
      else                       hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  logic [NUM_SW-1:0] deb_sw;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk (clk),
      .rst (reset),
      .raw (sw[i]),
      .deb (deb_sw[i])
    );
  end

  // rx resets to idle-high so the core never sees a start bit at release
  logic [1:0]        rx_sync;
  logic              rx_core;
  logic [NUM_SW-1:0] sw_core;
  logic [7:0]        cpu_switch;

  always_ff @(posedge core_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      rx_sync <= 2'b11;
      sw_core <= '0;
    end else begin
      rx_sync <= {rx_sync[0], UART_RX};
      sw_core <= deb_sw;
    end
  end

  assign rx_core = rx_sync[1];

  always_comb begin
    cpu_switch               = '0;
    cpu_switch[NUM_SW-1:0]   = sw_core;
  end

  board_out_t cpu_out;
  board_out_t pin_out;

  CPU_pipeline u_cpu (
    .clk     (core_clk),
    .reset   (cpu_rst),
    .switch  (cpu_switch),
    .UART_RX (rx_core),
    .led     (cpu_out.led),
    .digi    (cpu_out.digi),
    .UART_TX (cpu_out.uart_tx)
  );

  assign pin_out = cpu_rst ? BOARD_IDLE : cpu_out;
  assign led     = pin_out.led;
  assign digi    = pin_out.digi;
  assign UART_TX = pin_out.uart_tx;

endmodule
`default_nettype wire

// File: tb/tb_cpu_board_shell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_board_shell : directed scoreboard bench for cpu_board_shell    |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_cpu_board_shell;

  localparam int NUM_SW = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_SW-1:0] sw = '0;
  logic              uart_rx = 1'b1;
  logic [7:0]        led;
  logic [11:0]       digi;
  logic              uart_tx;
  logic              cpu_rst;

  cpu_board_shell #(
    .NUM_SW          (NUM_SW),
    .DEB_CYCLES      (8),
    .RST_SYNC_STAGES (2),
    .RST_HOLD        (4),
    .DIV_HALF        (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .UART_RX (uart_rx),
    .led     (led),
    .digi    (digi),
    .UART_TX (uart_tx),
    .cpu_rst (cpu_rst)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  bit          edge_timeout;

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_total++;
    if (exp_q.size() == 0) exp = 32'hDEAD_BEEF;
    else                   exp = exp_q.pop_front();
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clk_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // waits for a core_clk rising edge with a bounded budget, then moves to the next clk low phase
  task automatic core_edge(input string tag);
    edge_timeout = 1'b0;
    fork
      begin
        @(posedge dut.core_clk);
      end
      begin
        repeat (16) @(posedge clk);
        edge_timeout = 1'b1;
      end
    join_any
    disable fork;
    n_total++;
    assert (!edge_timeout) n_pass++;
    else $error("FAIL %s: observed no core_clk edge expected one within 16 clk", tag);
    @(negedge clk);
  endtask

  // after reset release: 2 sync edges + 4 hold edges, outputs masked until the last one
  task automatic run_release(input string tag);
    for (int e = 1; e <= 6; e++) begin
      push_exp((e < 6) ? 32'd1 : 32'd0);
      if (e < 6) begin
        push_exp(32'd1);
        push_exp(32'hFFF);
        push_exp(32'h00);
      end
      core_edge(tag);
      check({tag, "_cpu_rst"}, cpu_rst);
      if (e < 6) begin
        check({tag, "_tx_idle"}, uart_tx);
        check({tag, "_digi_idle"}, digi);
        check({tag, "_led_idle"}, led);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held for 3 clk: everything idle
    for (int k = 0; k < 3; k++) begin
      push_exp(32'd1); push_exp(32'h00); push_exp(32'hFFF); push_exp(32'd1);
      @(negedge clk);
      check("rst_cpu_rst", cpu_rst);
      check("rst_led", led);
      check("rst_digi", digi);
      check("rst_tx", uart_tx);
    end
    reset = 1'b0;
    run_release("release1");

    // restart mid-hold with a sub-cycle pulse; UART_RX held low across release
    @(negedge clk);
    reset   = 1'b1;
    uart_rx = 1'b0;
    clk_step();
    clk_step();
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      push_exp(32'd1);
      core_edge("pre_pulse");
      check("pre_pulse_cpu_rst", cpu_rst);
    end
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    push_exp(32'd1);
    #1 check("pulse_cpu_rst", cpu_rst);
    run_release("release2");
    push_exp(32'd1);
    check("rx_at_release", dut.rx_core);
    push_exp(32'd1);
    core_edge("rx_e7");
    check("rx_e7", dut.rx_core);
    push_exp(32'd0);
    core_edge("rx_e8");
    check("rx_e8", dut.rx_core);
    push_exp(32'd0);
    core_edge("tx_e9");
    check("tx_e9", uart_tx);

    // sw[0] rise held 20 clk, then a 5-clk glitch low
    @(negedge clk);
    sw[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      push_exp((k >= 10) ? 32'd1 : 32'd0);
      clk_step();
      check("deb_rise", dut.deb_sw[0]);
    end
    sw[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 6) sw[0] = 1'b1;
      push_exp(32'd1);
      clk_step();
      check("deb_glitch", dut.deb_sw[0]);
    end

    // A5 chattering every 3 clk, then held
    for (int p = 0; p < 16; p++) begin
      sw = (p % 2 == 0) ? 8'hA5 : 8'h00;
      for (int k = 0; k < 3; k++) begin
        push_exp(32'h01);
        clk_step();
        check("deb_chatter", dut.deb_sw);
      end
    end
    sw = 8'hA5;
    for (int k = 1; k <= 12; k++) begin
      push_exp((k >= 10) ? 32'hA5 : 32'h01);
      clk_step();
      check("deb_hold", dut.deb_sw);
    end
    push_exp(32'hA5);
    push_exp(32'h0A5);
    core_edge("led_path");
    core_edge("led_path");
    check("led_live", led);
    check("digi_live", digi);

`ifdef CLK_DIV_EN
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push_exp(32'd0);
      clk_step();
      check("core_clk_in_reset", dut.core_clk);
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push_exp(((k % 4) == 2 || (k % 4) == 3) ? 32'd1 : 32'd0);
      clk_step();
      check("core_clk_wave", dut.core_clk);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
